// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch resolver: branch type codes,
// BHT reset value and the taken/saturation helper functions.
package branch_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BEQ  = 3'b010;
    localparam logic [2:0] BR_BLEZ = 3'b011;
    localparam logic [2:0] BR_BGTZ = 3'b100;
    localparam logic [2:0] BR_BLTZ = 3'b101;
    localparam logic [2:0] BR_BGEZ = 3'b110;
    localparam logic [2:0] BR_RSVD = 3'b111;

    // Weakly not-taken.
    localparam logic [1:0] BHT_INIT = 2'b01;

    function automatic logic eh_branch(input logic [2:0] tipo);
        return (tipo != BR_NONE) && (tipo != BR_RSVD);
    endfunction

    function automatic logic [1:0] satura_contador(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

    // a_neg / a_zero are the sign bit and zero test of operando_a, so the
    // function stays independent of the datapath width.
    function automatic logic avalia_taken(input logic [2:0] tipo, input logic zero_ula,
                                          input logic a_neg, input logic a_zero);
        case (tipo)
            BR_BNE:  return !zero_ula;
            BR_BEQ:  return zero_ula;
            BR_BLEZ: return a_neg || a_zero;
            BR_BGTZ: return !a_neg && !a_zero;
            BR_BLTZ: return a_neg;
            BR_BGEZ: return !a_neg;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tabela_historico_branch.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port for fetch, one read-modify-write update port for EX.
module tabela_historico_branch
    import branch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] tabela_q [DEPTH];
    logic [1:0] tabela_d [DEPTH];

    // Fetch sees the registered contents, so a same-cycle update is not bypassed.
    assign rd_cnt = tabela_q[rd_idx];

    always_comb begin
        // NOTE: full default first so no path leaves tabela_d unassigned (no latch).
        tabela_d = tabela_q;
        if (wr_en) begin
            tabela_d[wr_idx] = satura_contador(tabela_q[wr_idx], wr_taken);
        end
    end

    // NOTE: the table is small flop storage, so it is reset like any other state;
    // a RAM-backed table could not be cleared in one cycle this way.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: non-blocking assignment for every sequential update.
                tabela_q[i] <= BHT_INIT;
            end
        end else begin
            tabela_q <= tabela_d;
        end
    end

endmodule

// File: rtl/controle_branch_preditor.sv
// EX-stage branch resolver: evaluates six MIPS branch types, trains the BHT,
// flags mispredictions and holds a multi-cycle flush with the redirect PC.
module controle_branch_preditor
    import branch_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int BHT_DEPTH    = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pc_busca,
    output logic              previsao_taken,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [2:0]        sinal_branch,
    input  logic [DATA_W-1:0] operando_a,
    input  logic              zero_ula,
    input  logic [DATA_W-1:0] pc_branch,
    input  logic [DATA_W-1:0] pc_alvo,
    input  logic              previsto_taken,
    output logic              output_controle_branch,
    output logic              mispredict,
    output logic              flush,
    output logic [DATA_W-1:0] pc_correcao,
    output logic [CNT_W-1:0]  cnt_branches,
    output logic [CNT_W-1:0]  cnt_mispredict
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    logic              taken_q, taken_d;
    logic              mispredict_q, mispredict_d;
    logic              flush_q, flush_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [DATA_W-1:0] pc_correcao_q, pc_correcao_d;
    logic [CNT_W-1:0]  cnt_branches_q, cnt_branches_d;
    logic [CNT_W-1:0]  cnt_mispredict_q, cnt_mispredict_d;

    logic       accept;
    logic       taken;
    logic       erro;
    logic [1:0] bht_rd;
    logic       unused_pc_busca;

    // Only the word-index bits of the fetch PC select a BHT entry.
    assign unused_pc_busca = ^{pc_busca[DATA_W-1:IDX_W+2], pc_busca[1:0]};

    tabela_historico_branch #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (pc_busca[IDX_W+1:2]),
        .rd_cnt   (bht_rd),
        .wr_en    (accept),
        .wr_idx   (pc_branch[IDX_W+1:2]),
        .wr_taken (taken)
    );

    assign res_ready = !flush_q;
    assign accept    = res_valid && res_ready && eh_branch(sinal_branch);
    assign taken     = avalia_taken(sinal_branch, zero_ula, operando_a[DATA_W-1],
                                    operando_a == '0);
    assign erro      = taken != previsto_taken;

    always_comb begin
        taken_d          = taken_q;
        mispredict_d     = 1'b0;
        flush_d          = flush_q;
        flush_cnt_d      = flush_cnt_q;
        pc_correcao_d    = pc_correcao_q;
        cnt_branches_d   = cnt_branches_q;
        cnt_mispredict_d = cnt_mispredict_q;

        // accept and an active flush are mutually exclusive through res_ready.
        if (accept) begin
            taken_d      = taken;
            mispredict_d = erro;
            if (cnt_branches_q != '1) begin
                cnt_branches_d = cnt_branches_q + 1'b1;
            end
            if (erro) begin
                pc_correcao_d = taken ? pc_alvo : pc_branch + DATA_W'(4);
                flush_d       = 1'b1;
                flush_cnt_d   = FC_W'(FLUSH_CYCLES);
                if (cnt_mispredict_q != '1) begin
                    cnt_mispredict_d = cnt_mispredict_q + 1'b1;
                end
            end
        end else if (flush_q) begin
            flush_cnt_d = flush_cnt_q - 1'b1;
            flush_d     = flush_cnt_q > FC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_q          <= 1'b0;
            mispredict_q     <= 1'b0;
            flush_q          <= 1'b0;
            flush_cnt_q      <= '0;
            pc_correcao_q    <= '0;
            cnt_branches_q   <= '0;
            cnt_mispredict_q <= '0;
        end else begin
            taken_q          <= taken_d;
            mispredict_q     <= mispredict_d;
            flush_q          <= flush_d;
            flush_cnt_q      <= flush_cnt_d;
            pc_correcao_q    <= pc_correcao_d;
            cnt_branches_q   <= cnt_branches_d;
            cnt_mispredict_q <= cnt_mispredict_d;
        end
    end

    assign previsao_taken         = bht_rd[1];
    assign output_controle_branch = taken_q;
    assign mispredict             = mispredict_q;
    assign flush                  = flush_q;
    assign pc_correcao            = pc_correcao_q;
    assign cnt_branches           = cnt_branches_q;
    assign cnt_mispredict         = cnt_mispredict_q;

endmodule

// File: tb/tb_controle_branch_preditor.sv
// Bench for controle_branch_preditor: scenario tasks plus a scoreboard that
// predicts each accepted branch's outcome and checks it one cycle later.
module tb_controle_branch_preditor;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [2:0] T_BNE = 3'd1;
    localparam logic [2:0] T_BEQ = 3'd2;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] pc_busca;
    logic              previsao_taken;
    logic              res_valid;
    logic              res_ready;
    logic [2:0]        sinal_branch;
    logic [DATA_W-1:0] operando_a;
    logic              zero_ula;
    logic [DATA_W-1:0] pc_branch;
    logic [DATA_W-1:0] pc_alvo;
    logic              previsto_taken;
    logic              output_controle_branch;
    logic              mispredict;
    logic              flush;
    logic [DATA_W-1:0] pc_correcao;
    logic [CNT_W-1:0]  cnt_branches;
    logic [CNT_W-1:0]  cnt_mispredict;

    controle_branch_preditor #(
        .DATA_W       (DATA_W),
        .BHT_DEPTH    (16),
        .FLUSH_CYCLES (2),
        .CNT_W        (CNT_W)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .pc_busca               (pc_busca),
        .previsao_taken         (previsao_taken),
        .res_valid              (res_valid),
        .res_ready              (res_ready),
        .sinal_branch           (sinal_branch),
        .operando_a             (operando_a),
        .zero_ula               (zero_ula),
        .pc_branch              (pc_branch),
        .pc_alvo                (pc_alvo),
        .previsto_taken         (previsto_taken),
        .output_controle_branch (output_controle_branch),
        .mispredict             (mispredict),
        .flush                  (flush),
        .pc_correcao            (pc_correcao),
        .cnt_branches           (cnt_branches),
        .cnt_mispredict         (cnt_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic              taken;
        logic              misp;
        logic [DATA_W-1:0] pc_corr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_push;
    exp_t mon_pop;
    int   model_br  = 0;
    int   model_mis = 0;

    function automatic logic ref_taken(input logic [2:0] t, input logic z, input logic [31:0] a);
        case (t)
            3'd1:    return !z;
            3'd2:    return z;
            3'd3:    return a[31] || (a == 32'h0);
            3'd4:    return !a[31] && (a != 32'h0);
            3'd5:    return a[31];
            3'd6:    return !a[31];
            default: return 1'b0;
        endcase
    endfunction

    // Push side: observe the handshake at the edge and predict the result.
    always @(posedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            model_br  = 0;
            model_mis = 0;
        end else if (res_valid && res_ready && sinal_branch != 3'd0 && sinal_branch != 3'd7) begin
            mon_push.taken   = ref_taken(sinal_branch, zero_ula, operando_a);
            mon_push.misp    = mon_push.taken != previsto_taken;
            mon_push.pc_corr = mon_push.taken ? pc_alvo : pc_branch + 32'd4;
            sb_q.push_back(mon_push);
            model_br++;
            if (mon_push.misp) model_mis++;
        end
    end

    // Pop side: the result is visible half a cycle after the accepting edge.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_pop = sb_q.pop_front();
            checks++;
            if (output_controle_branch !== mon_pop.taken)
                $display("FAIL sb_taken got=%0b exp=%0b", output_controle_branch, mon_pop.taken);
            else passed++;
            checks++;
            if (mispredict !== mon_pop.misp)
                $display("FAIL sb_mispredict got=%0b exp=%0b", mispredict, mon_pop.misp);
            else passed++;
            if (mon_pop.misp) begin
                checks++;
                if (pc_correcao !== mon_pop.pc_corr)
                    $display("FAIL sb_pc_correcao got=%h exp=%h", pc_correcao, mon_pop.pc_corr);
                else passed++;
            end
        end
    end

    task automatic do_reset();
        rst_n        = 1'b0;
        res_valid    = 1'b0;
        sinal_branch = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Drive one request and hold it until accepted; returns 1 time unit after the edge.
    task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic z,
                         input logic [31:0] pcb, input logic [31:0] alvo, input logic prev);
        bit ok;
        sinal_branch   = t;
        operando_a     = a;
        zero_ula       = z;
        pc_branch      = pcb;
        pc_alvo        = alvo;
        previsto_taken = prev;
        res_valid      = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            ok = res_ready;
            @(posedge clk);
        end
        #1;
        res_valid = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL issue_timeout type=%0d pc=%h", t, pcb);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (output_controle_branch !== 1'b0) $display("FAIL reset_taken got=%0b exp=0", output_controle_branch); else passed++;
        checks++; if (mispredict !== 1'b0) $display("FAIL reset_mispredict got=%0b exp=0", mispredict); else passed++;
        checks++; if (flush !== 1'b0) $display("FAIL reset_flush got=%0b exp=0", flush); else passed++;
        checks++; if (res_ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", res_ready); else passed++;
        checks++; if (pc_correcao !== 32'h0) $display("FAIL reset_pc_correcao got=%h exp=0", pc_correcao); else passed++;
        checks++; if (cnt_branches !== 16'd0) $display("FAIL reset_cnt_branches got=%0d exp=0", cnt_branches); else passed++;
        checks++; if (cnt_mispredict !== 16'd0) $display("FAIL reset_cnt_mispredict got=%0d exp=0", cnt_mispredict); else passed++;
        pc_busca = 32'h7C; #1;
        checks++; if (previsao_taken !== 1'b0) $display("FAIL reset_previsao got=%0b exp=0", previsao_taken); else passed++;
    endtask

    task automatic test_beq_mispredict();
        issue(T_BEQ, 32'h0, 1'b1, 32'h40, 32'h80, 1'b0);
        checks++; if (mispredict !== 1'b1) $display("FAIL beq_mispredict got=%0b exp=1", mispredict); else passed++;
        checks++; if (flush !== 1'b1) $display("FAIL beq_flush1 got=%0b exp=1", flush); else passed++;
        checks++; if (pc_correcao !== 32'h80) $display("FAIL beq_pc_correcao got=%h exp=80", pc_correcao); else passed++;
        checks++; if (res_ready !== 1'b0) $display("FAIL beq_ready got=%0b exp=0", res_ready); else passed++;
        @(posedge clk); #1;
        checks++; if (mispredict !== 1'b0) $display("FAIL beq_pulse_width got=%0b exp=0", mispredict); else passed++;
        checks++; if (flush !== 1'b1) $display("FAIL beq_flush2 got=%0b exp=1", flush); else passed++;
        @(posedge clk); #1;
        checks++; if (flush !== 1'b0) $display("FAIL beq_flush_end got=%0b exp=0", flush); else passed++;
        pc_busca = 32'h40; #1;
        checks++; if (previsao_taken !== 1'b1) $display("FAIL beq_bht0 got=%0b exp=1", previsao_taken); else passed++;
        checks++; if (cnt_mispredict !== CNT_W'(model_mis)) $display("FAIL beq_cnt_mis got=%0d exp=%0d", cnt_mispredict, model_mis); else passed++;
    endtask

    task automatic test_bne_floor();
        repeat (2) begin
            issue(T_BNE, 32'h0, 1'b1, 32'h44, 32'h100, 1'b0);
            checks++; if (flush !== 1'b0) $display("FAIL bne_no_flush got=%0b exp=0", flush); else passed++;
        end
        pc_busca = 32'h44; #1;
        checks++; if (previsao_taken !== 1'b0) $display("FAIL bne_bht1 got=%0b exp=0", previsao_taken); else passed++;
        // From the 00 floor two taken updates reach 10; a wrapped counter would not.
        repeat (2) issue(T_BNE, 32'h0, 1'b0, 32'h44, 32'h100, 1'b1);
        #1;
        checks++; if (previsao_taken !== 1'b1) $display("FAIL bne_bht_floor got=%0b exp=1", previsao_taken); else passed++;
    endtask

    task automatic test_signed();
        logic [31:0] avals [3];
        bit          exp_tab [4][3];
        int          br0;
        avals   = '{32'h0, 32'h1, 32'h8000_0000};
        exp_tab = '{'{1, 0, 1}, '{0, 1, 0}, '{0, 0, 1}, '{1, 1, 0}};
        br0 = model_br;
        issue(3'd0, 32'h0, 1'b1, 32'h300, 32'h400, 1'b0);
        issue(3'd7, 32'h0, 1'b1, 32'h300, 32'h400, 1'b0);
        checks++; if (cnt_branches !== CNT_W'(br0)) $display("FAIL nonbranch_cnt got=%0d exp=%0d", cnt_branches, br0); else passed++;
        checks++; if (mispredict !== 1'b0) $display("FAIL nonbranch_mispredict got=%0b exp=0", mispredict); else passed++;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 3; k++) begin
                issue(3'(3 + t), avals[k], 1'b0, 32'h200, 32'h300, 1'b0);
                checks++;
                if (output_controle_branch !== exp_tab[t][k])
                    $display("FAIL signed_type%0d_a%h got=%0b exp=%0b", 3 + t, avals[k], output_controle_branch, exp_tab[t][k]);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(T_BEQ, 32'h0, 1'b1, 32'h40, 32'h80, 1'b0);
        sinal_branch   = T_BNE;
        zero_ula       = 1'b1;
        previsto_taken = 1'b0;
        pc_branch      = 32'h48;
        res_valid      = 1'b1;
        checks++; if (res_ready !== 1'b0) $display("FAIL hold_ready_c1 got=%0b exp=0", res_ready); else passed++;
        @(posedge clk); #1;
        checks++; if (res_ready !== 1'b0) $display("FAIL hold_ready_c2 got=%0b exp=0", res_ready); else passed++;
        checks++; if (cnt_branches !== 16'd1) $display("FAIL hold_cnt_early got=%0d exp=1", cnt_branches); else passed++;
        @(posedge clk); #1;
        checks++; if (res_ready !== 1'b1) $display("FAIL hold_ready_c3 got=%0b exp=1", res_ready); else passed++;
        @(posedge clk); #1;
        res_valid = 1'b0;
        checks++; if (cnt_branches !== 16'd2) $display("FAIL hold_cnt_branches got=%0d exp=2", cnt_branches); else passed++;
    endtask

    task automatic test_bht_saturate();
        do_reset();
        pc_busca       = 32'h40;
        sinal_branch   = T_BEQ;
        zero_ula       = 1'b1;
        previsto_taken = 1'b1;
        pc_branch      = 32'h40;
        pc_alvo        = 32'h80;
        res_valid      = 1'b1;
        #1;
        checks++; if (previsao_taken !== 1'b0) $display("FAIL bht_no_bypass got=%0b exp=0", previsao_taken); else passed++;
        @(posedge clk); #1;
        res_valid = 1'b0;
        checks++; if (previsao_taken !== 1'b1) $display("FAIL bht_after_first got=%0b exp=1", previsao_taken); else passed++;
        repeat (2) issue(T_BEQ, 32'h0, 1'b1, 32'h40, 32'h80, 1'b1);
        res_valid = 1'b1;
        #1;
        checks++; if (previsao_taken !== 1'b1) $display("FAIL bht_fourth_old got=%0b exp=1", previsao_taken); else passed++;
        @(posedge clk); #1;
        res_valid = 1'b0;
        checks++; if (cnt_branches !== 16'd4) $display("FAIL bht_cnt_branches got=%0d exp=4", cnt_branches); else passed++;
        // One not-taken step from a saturated 11 must leave the MSB set.
        issue(T_BEQ, 32'h0, 1'b0, 32'h40, 32'h80, 1'b0);
        #1;
        checks++; if (previsao_taken !== 1'b1) $display("FAIL bht_sat_ceiling got=%0b exp=1", previsao_taken); else passed++;
    endtask

    task automatic test_wrap_reset();
        issue(T_BEQ, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h10, 1'b1);
        checks++; if (mispredict !== 1'b1) $display("FAIL wrap_mispredict got=%0b exp=1", mispredict); else passed++;
        checks++; if (pc_correcao !== 32'h0) $display("FAIL wrap_pc_correcao got=%h exp=0", pc_correcao); else passed++;
        checks++; if (flush !== 1'b1) $display("FAIL wrap_flush got=%0b exp=1", flush); else passed++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (flush !== 1'b0) $display("FAIL midflush_flush got=%0b exp=0", flush); else passed++;
        checks++; if (res_ready !== 1'b1) $display("FAIL midflush_ready got=%0b exp=1", res_ready); else passed++;
        checks++; if (output_controle_branch !== 1'b0) $display("FAIL midflush_taken got=%0b exp=0", output_controle_branch); else passed++;
        checks++; if (cnt_mispredict !== 16'd0) $display("FAIL midflush_cnt_mis got=%0d exp=0", cnt_mispredict); else passed++;
        pc_busca = 32'h40; #1;
        checks++; if (previsao_taken !== 1'b0) $display("FAIL midflush_bht got=%0b exp=0", previsao_taken); else passed++;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        pc_busca       = '0;
        res_valid      = 1'b0;
        sinal_branch   = 3'd0;
        operando_a     = '0;
        zero_ula       = 1'b0;
        pc_branch      = '0;
        pc_alvo        = '0;
        previsto_taken = 1'b0;

        test_reset();
        test_beq_mispredict();
        test_bne_floor();
        test_signed();
        test_back_to_back();
        test_bht_saturate();
        test_wrap_reset();

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
